// File: rtl/ddr_pkg.sv
// Shared definitions for the dance-game note path: note codes, lane masks and
// the sequencer state encoding also shown on the debug/LED display.
package ddr_pkg;

  localparam int unsigned NOTE_BITS = 4;

  localparam logic [NOTE_BITS-1:0] NOTE_END   = 4'b1111;
  localparam logic [NOTE_BITS-1:0] LANE_LEFT  = 4'b0001;
  localparam logic [NOTE_BITS-1:0] LANE_DOWN  = 4'b0010;
  localparam logic [NOTE_BITS-1:0] LANE_UP    = 4'b0100;
  localparam logic [NOTE_BITS-1:0] LANE_RIGHT = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_CHECK     = 3'd2,
    ST_OFFER     = 3'd3,
    ST_WAIT_BEAT = 3'd4,
    ST_DONE      = 3'd5
  } seq_state_e;

  // States in which a level is in progress and the beat timebase runs.
  function automatic logic is_running(seq_state_e s);
    return (s == ST_FETCH) || (s == ST_CHECK) || (s == ST_OFFER) || (s == ST_WAIT_BEAT);
  endfunction

endpackage

// File: rtl/beat_timer.sv
// Beat timebase: counts enabled cycles 0..BEAT_DIV-1 and flags the last one.
module beat_timer #(
  parameter int unsigned BEAT_DIV = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEAT_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick_c = en && (count == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick_c ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Walks the level ROM one note per beat and offers each arrow pattern
// downstream over valid/ready; tracks end-of-level and dropped beats.
module note_sequencer
  import ddr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned BEAT_DIV   = 12_500_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pause,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_note,
  output logic [DATA_WIDTH-1:0] note,
  output logic                  note_valid,
  input  logic                  note_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  missed
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
  localparam logic [DATA_WIDTH-1:0] END_CODE  = DATA_WIDTH'(NOTE_END);

  seq_state_e            state, state_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] note_n;
  logic                  valid_n;
  logic                  missed_n;
  logic                  pending, pending_n;
  logic                  timer_en, timer_clr, tick;
  logic                  handshake, consume;

  assign handshake = note_valid && note_ready;
  assign timer_en  = is_running(state) && !pause;

  beat_timer #(.BEAT_DIV(BEAT_DIV)) u_beat_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (timer_en),
    .clr    (timer_clr),
    .tick_c (tick)
  );

  always_comb begin
    state_n   = state;
    addr_n    = rom_addr;
    note_n    = note;
    valid_n   = note_valid;
    missed_n  = missed;
    pending_n = pending;
    timer_clr = 1'b0;
    consume   = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n   = ST_FETCH;
          addr_n    = '0;
          timer_clr = 1'b1;
        end
      end
      ST_FETCH: begin
        if (!pause) state_n = ST_CHECK;
      end
      ST_CHECK: begin
        if (!pause) begin
          if (rom_note == END_CODE) begin
            state_n = ST_DONE;
          end else begin
            note_n  = rom_note;
            valid_n = 1'b1;
            state_n = ST_OFFER;
          end
        end
      end
      // Handshake is honoured even while paused so downstream never stalls.
      ST_OFFER: begin
        if (handshake) begin
          valid_n = 1'b0;
          if (rom_addr == ADDR_LAST) begin
            state_n = ST_DONE;
          end else begin
            addr_n  = rom_addr + ADDR_WIDTH'(1);
            consume = pending || tick;
            state_n = consume ? ST_FETCH : ST_WAIT_BEAT;
          end
        end
      end
      ST_WAIT_BEAT: begin
        if (tick) state_n = ST_FETCH;
      end
      default: state_n = ST_IDLE;
    endcase

    // One-deep beat bank; a second unconsumed beat is dropped and flagged.
    if (tick && (state != ST_WAIT_BEAT)) begin
      pending_n = pending || !consume;
      if (pending && !consume) missed_n = 1'b1;
    end else begin
      pending_n = pending && !consume;
    end

    if (timer_clr) begin
      pending_n = 1'b0;
      missed_n  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rom_addr   <= '0;
      note       <= '0;
      note_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      missed     <= 1'b0;
      pending    <= 1'b0;
    end else begin
      state      <= state_n;
      rom_addr   <= addr_n;
      note       <= note_n;
      note_valid <= valid_n;
      busy       <= is_running(state_n);
      done       <= (state_n == ST_DONE);
      missed     <= missed_n;
      pending    <= pending_n;
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed scenarios plus random levels, each cycle
// compared against a beat-banking reference model of the sequencer.
module tb_note_sequencer;
  import ddr_pkg::*;

  localparam int AW = 6;
  localparam int DW = 4;
  localparam int BD = 8;
  localparam int LAST_ADDR = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst, start, pause, note_ready;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_note, note;
  logic          note_valid, busy, done, missed;

  logic [DW-1:0] rom_mem [64];

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int cyc = 0, s_t = 0, done_t = -1;

  logic [DW-1:0] acc_note [$];
  int            acc_t [$];
  int            acc_addr [$];

  // Reference model: level progress, banked beats, enabled-cycle clock.
  bit            m_active, m_offer, m_wait, m_done, m_missed, m_valid;
  int            m_addr, m_owed, m_enabled, m_age;
  logic [DW-1:0] m_note;

  note_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEAT_DIV(BD)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pause      (pause),
    .rom_addr   (rom_addr),
    .rom_note   (rom_note),
    .note       (note),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .busy       (busy),
    .done       (done),
    .missed     (missed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_note <= rom_mem[rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit beat;
    int avail;
    if (rst) begin
      m_active = 0; m_offer = 0; m_wait = 0; m_done = 0; m_missed = 0; m_valid = 0;
      m_addr = 0; m_owed = 0; m_enabled = 0; m_age = 0; m_note = '0;
      return;
    end
    beat = 0;
    if (m_active && !pause) begin
      m_enabled++;
      beat = (m_enabled % BD) == 0;
    end
    if (!m_active) begin
      if (start) begin
        m_active = 1; m_done = 0; m_missed = 0; m_owed = 0; m_enabled = 0;
        m_addr = 0; m_age = 0; m_offer = 0; m_wait = 0;
      end
    end else if (m_offer) begin
      if (note_ready) begin
        m_offer = 0; m_valid = 0;
        if (m_addr == LAST_ADDR) begin
          m_active = 0; m_done = 1;
        end else begin
          m_addr++;
          avail = m_owed + int'(beat);
          if (avail > 0) begin avail--; m_age = 0; end
          else m_wait = 1;
          m_owed = avail;
        end
      end else if (beat) begin
        if (m_owed > 0) m_missed = 1;
        m_owed = 1;
      end
    end else if (m_wait) begin
      if (beat) begin m_wait = 0; m_age = 0; end
    end else if (!pause) begin
      if (beat) begin
        if (m_owed > 0) m_missed = 1;
        m_owed = 1;
      end
      m_age++;
      if (m_age == 2) begin
        if (rom_mem[m_addr] == NOTE_END) begin
          m_active = 0; m_done = 1;
        end else begin
          m_note = rom_mem[m_addr]; m_valid = 1; m_offer = 1;
        end
      end
    end
  endtask

  task automatic step();
    if (note_valid === 1'b1 && note_ready === 1'b1) begin
      acc_note.push_back(note); acc_t.push_back(cyc); acc_addr.push_back(int'(rom_addr));
    end
    @(posedge clk);
    model_edge();
    #1;
    check("rom_addr", 32'(rom_addr), 32'(m_addr));
    check("note", 32'(note), 32'(m_note));
    check("note_valid", 32'(note_valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_active));
    check("done", 32'(done), 32'(m_done));
    check("missed", 32'(missed), 32'(m_missed));
    if (done === 1'b1 && done_t < 0) done_t = cyc;
    cyc++;
  endtask

  task automatic pulse_start();
    acc_note.delete(); acc_t.delete(); acc_addr.delete();
    done_t = -1;
    s_t = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    for (int c = 0; c < budget && done !== 1'b1; c++) step();
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    for (int c = 0; c < budget && note_valid !== 1'b1; c++) step();
    check(tag, 32'(note_valid), 32'd1);
  endtask

  task automatic fill_rom(input int end_pos);
    for (int i = 0; i < 64; i++) rom_mem[i] = 4'($urandom_range(0, 14));
    if (end_pos >= 0 && end_pos < 64) rom_mem[end_pos] = NOTE_END;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; note_ready = 1'b1;
    fill_rom(-1);
    step(); step();
    rst = 1'b0;
    step();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);

    // Basic level, ready tied high.
    rom_mem[0] = LANE_LEFT; rom_mem[1] = LANE_RIGHT; rom_mem[2] = LANE_DOWN; rom_mem[3] = NOTE_END;
    pulse_start();
    run_until_done("s1_done", 100);
    check("s1_acc_count", 32'(acc_note.size()), 32'd3);
    if (acc_note.size() == 3) begin
      check("s1_note0", 32'(acc_note[0]), 32'(LANE_LEFT));
      check("s1_note1", 32'(acc_note[1]), 32'(LANE_RIGHT));
      check("s1_note2", 32'(acc_note[2]), 32'(LANE_DOWN));
      check("s1_first_valid", 32'(acc_t[0] - s_t), 32'd3);
      check("s1_gap01", 32'(acc_t[1] - acc_t[0]), 32'd8);
      check("s1_gap12", 32'(acc_t[2] - acc_t[1]), 32'd8);
    end
    check("s1_done_time", 32'(done_t - s_t), 32'd26);
    step(); step();

    // First note held for 5 cycles; second still lands on beat 2.
    rom_mem[0] = LANE_UP; rom_mem[1] = LANE_RIGHT; rom_mem[2] = LANE_DOWN | LANE_LEFT; rom_mem[3] = NOTE_END;
    note_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 7; i++) step();
    note_ready = 1'b1;
    run_until_done("s2_done", 100);
    check("s2_acc_count", 32'(acc_note.size()), 32'd3);
    if (acc_note.size() == 3) begin
      check("s2_acc0_time", 32'(acc_t[0] - s_t), 32'd8);
      check("s2_acc1_time", 32'(acc_t[1] - s_t), 32'd11);
    end
    check("s2_missed", 32'(missed), 32'd0);

    // First note held for 20 cycles: bank one beat, drop the next.
    rom_mem[0] = LANE_DOWN; rom_mem[1] = LANE_UP; rom_mem[2] = LANE_LEFT; rom_mem[3] = LANE_RIGHT; rom_mem[4] = NOTE_END;
    note_ready = 1'b0;
    pulse_start();
    for (int i = 1; i <= 22; i++) begin
      step();
      if (i == 15) check("s3_missed_before", 32'(missed), 32'd0);
      if (i == 16) check("s3_missed_beat2", 32'(missed), 32'd1);
    end
    note_ready = 1'b1;
    run_until_done("s3_done", 100);
    check("s3_acc_count", 32'(acc_note.size()), 32'd4);
    if (acc_note.size() == 4) begin
      check("s3_acc0_time", 32'(acc_t[0] - s_t), 32'd23);
      check("s3_refetch_gap", 32'(acc_t[1] - acc_t[0]), 32'd3);
      check("s3_addr_step", 32'(acc_addr[1]), 32'd1);
    end

    // Restart from DONE clears missed and rewinds the address.
    pulse_start();
    check("restart_missed", 32'(missed), 32'd0);
    check("restart_addr", 32'(rom_addr), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    run_until_done("restart_level_done", 100);

    // Pause in WAIT_BEAT stretches the beat; pause in OFFER still hands off.
    rom_mem[0] = LANE_LEFT; rom_mem[1] = LANE_UP; rom_mem[2] = LANE_RIGHT; rom_mem[3] = LANE_DOWN; rom_mem[4] = NOTE_END;
    pulse_start();
    for (int i = 0; i < 3; i++) step();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) step();
    pause = 1'b0;
    wait_valid("s4_valid2", 40);
    step();
    check("s4_acc_count2", 32'(acc_note.size()), 32'd2);
    if (acc_note.size() == 2) check("s4_paused_delay", 32'(acc_t[1] - s_t), 32'd21);
    wait_valid("s4_valid3", 40);
    pause = 1'b1;
    step();
    check("s4_offer_hs", 32'(note_valid), 32'd0);
    check("s4_acc_count3", 32'(acc_note.size()), 32'd3);
    pause = 1'b0;
    run_until_done("s4_done", 100);

    // No end marker: all 64 entries, stop at the last address.
    fill_rom(-1);
    pulse_start();
    run_until_done("s5_done", 64 * BD + 40);
    check("s5_acc_count", 32'(acc_note.size()), 32'd64);
    step(); step();
    check("s5_addr_nowrap", 32'(rom_addr), 32'(LAST_ADDR));

    // Reset while offering, with missed already set.
    fill_rom(6);
    note_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 20; i++) step();
    check("s6_pre_valid", 32'(note_valid), 32'd1);
    check("s6_pre_missed", 32'(missed), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("s6_rst_addr", 32'(rom_addr), 32'd0);
    check("s6_rst_note", 32'(note), 32'd0);
    check("s6_rst_valid", 32'(note_valid), 32'd0);
    check("s6_rst_busy", 32'(busy), 32'd0);
    check("s6_rst_done", 32'(done), 32'd0);
    check("s6_rst_missed", 32'(missed), 32'd0);
    note_ready = 1'b1;
    step();

    // Start mid-level is ignored.
    fill_rom(5);
    pulse_start();
    for (int i = 0; i < 5; i++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("s7_ign_busy", 32'(busy), 32'd1);
    check("s7_ign_addr", 32'(rom_addr), 32'd1);
    run_until_done("s7_done", 100);
    check("s7_acc_count", 32'(acc_note.size()), 32'd5);
    if (acc_note.size() == 5) check("s7_beat2", 32'(acc_t[1] - s_t), 32'd11);

    // Random levels with random ready, pause and stray starts.
    for (int lv = 0; lv < 6; lv++) begin
      fill_rom(int'($urandom_range(3, 18)));
      pause = 1'b0; note_ready = 1'b1;
      pulse_start();
      for (int c = 0; c < 500 && done !== 1'b1; c++) begin
        note_ready = ($urandom_range(0, 3) != 0);
        pause      = ($urandom_range(0, 11) == 0);
        start      = ($urandom_range(0, 59) == 0);
        step();
      end
      start = 1'b0; pause = 1'b0; note_ready = 1'b1;
      check("rand_level_done", 32'(done), 32'd1);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Steps one level's note ROM at a fixed beat rate and hands each arrow pattern to the arrow-spawning logic over a valid/ready handshake. Sits between the level ROM (synchronous read, 1-cycle latency, 4'b1111 end-of-level marker) and the on-screen arrow generator. Owns the ROM address, the beat timebase, pause handling and end-of-level detection.

## Interface
Parameters:
- ADDR_WIDTH, 6, ROM address width
- DATA_WIDTH, 4, note width; one bit per arrow lane
- BEAT_DIV, 12_500_000, clk cycles per beat (≥4)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins the level from address 0; ignored while busy
- pause  in  1  level; freezes the beat counter and state advance
- rom_addr  out  ADDR_WIDTH  address to level ROM
- rom_note  in  DATA_WIDTH  registered ROM output, valid 1 cycle after rom_addr
- note  out  DATA_WIDTH  current arrow pattern
- note_valid  out  1  note is offered downstream
- note_ready  in  1  downstream accepts note
- busy  out  1  high from the cycle after start until done
- done  out  1  level finished; held until next start or rst
- missed  out  1  sticky; a beat arrived while one was already pending

## Operation
- States: IDLE, FETCH, CHECK, OFFER, WAIT_BEAT, DONE.
- IDLE: rom_addr=0. start → FETCH; beat counter cleared, missed cleared.
- FETCH: rom_addr stable for one cycle → CHECK.
- CHECK: rom_note==NOTE_END → DONE. Otherwise register note, note_valid=1 → OFFER.
- OFFER: hold note/note_valid until note_valid&&note_ready. On handshake, note_valid=0 and rom_addr+1. If rom_addr was 2^ADDR_WIDTH-1, go to DONE (no wrap). Else pending beat set → FETCH; else → WAIT_BEAT.
- WAIT_BEAT: beat tick → FETCH.
- DONE: done=1, busy=0. start → FETCH from address 0 (same as IDLE start).
- Beat counter runs in FETCH/CHECK/OFFER/WAIT_BEAT while pause=0. It counts 0..BEAT_DIV-1, and the tick is the cycle the counter equals BEAT_DIV-1 (then wraps to 0).
- Pending beat: a tick outside WAIT_BEAT sets a one-deep pending flag. A tick while pending is already set sets missed; that beat is dropped.
- pause=1: counter holds and no state transitions occur. The exception is OFFER, where the handshake is still honoured. note/note_valid are held.
- start in FETCH/CHECK/OFFER/WAIT_BEAT is ignored.
- rst at any point: IDLE. rom_addr=0, note=0, note_valid=0, busy=0, done=0, missed=0, counter=0, pending=0.

## Timing
- start sampled in cycle t: FETCH in t+1 with rom_addr=0; CHECK in t+2; note_valid=1 from t+3.
- Each fetch takes 2 cycles (FETCH, CHECK) before note_valid rises.
- Beats are spaced by exactly BEAT_DIV unpaused cycles measured from start, independent of handshake delay, provided the handshake completes before the next tick.
- All outputs are registered; no combinational path from note_ready to note_valid.
- End marker: done rises 1 cycle after CHECK sees NOTE_END; no note_valid is issued for the marker.

## Structure
- Shared package ddr_pkg:
  - NOTE_END = 4'b1111
  - lane one-hot constants
  - sequencer state encoding (shared with the debug/LED display)
- Sub-module beat_timer: counter with enable/clear, tick output, parameter BEAT_DIV.
- The FSM, address counter and pending/missed flags stay in note_sequencer.

## Test plan
All scenarios use BEAT_DIV=8 and a behavioural 1-cycle ROM model.
- ROM {0001,1000,0010,1111}, note_ready tied 1, start at t=0:
  - notes 0001, 1000, 0010 each accepted, 8 cycles apart;
  - first note_valid at t=3;
  - done at the cycle after CHECK of address 3;
  - no note_valid for 1111.
- note_ready low for 5 cycles on the first note: note/note_valid held stable; second note still offered on beat 2 (t=8+3); missed=0.
- note_ready low for 20 cycles:
  - pending set at beat 1; missed=1 at beat 2;
  - after acceptance, next note fetched immediately (note_valid 3 cycles later);
  - address advances by 1 only.
- pause high for 10 cycles in WAIT_BEAT: next note_valid delayed by exactly 10 cycles; pause during OFFER with note_ready=1 still completes the handshake.
- ROM with no 1111 in 64 entries: 64 notes delivered; done after address 63 accepted; rom_addr does not wrap.
- rst asserted in OFFER: next cycle all outputs at reset values. start mid-level is ignored. start in DONE restarts at address 0 with missed cleared.
